// File: rtl/hyperram_req_bridge.sv
// hyperram_req_bridge: buffers upstream read/write requests and issues them one at a time to the HyperRAM controller.
// Optional read timeout enabled by defining HYPERRAM_REQ_BRIDGE_RD_TIMEOUT_EN.
module hyperram_req_bridge #(
  parameter int DEPTH = 4,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic [31:0] addr,
  output logic        wr_req,
  output logic        rd_req,
  output logic [31:0] wdata,
  output logic [3:0]  wr_byte_en,
  input  logic        busy,
  input  logic        rd_rdy,
  input  logic [31:0] rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, GAP, WAIT_BUSY, WAIT_RD} state_t;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RD_TIMEOUT < 1) begin : g_param_check
    $error("hyperram_req_bridge: DEPTH must be a power of two >= 2 and RD_TIMEOUT >= 1");
  end
  state_t state, state_nx;
  logic [68:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic cur_we, push, pop, rsp_ok, rsp_tmo;
  logic hd_we;
  logic [31:0] hd_addr, hd_wdata;
  logic [3:0] hd_be;
  assign {hd_we, hd_addr, hd_wdata, hd_be} = mem[rp];
  // Ready is held low while reset is asserted so every output reads 0 during reset.
  assign req_ready = !reset && count < (AW+1)'(DEPTH);
  assign push = req_valid && req_ready;
  assign rsp_ok = state == WAIT_RD && rd_rdy;
  always_comb begin
    pop = state == IDLE && count != '0 && !busy;
    state_nx = state == IDLE      ? (pop ? GAP : IDLE) :
               state == GAP       ? (cur_we ? WAIT_BUSY : WAIT_RD) :
               state == WAIT_BUSY ? (busy ? WAIT_BUSY : IDLE) :
                                    (rsp_ok || rsp_tmo ? WAIT_BUSY : WAIT_RD);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      cur_we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wr_byte_en <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wr_req <= pop && hd_we;
      rd_req <= pop && !hd_we;
      rsp_valid <= rsp_ok || rsp_tmo;
      if (pop) begin
        cur_we <= hd_we;
        addr <= hd_addr;
        wdata <= hd_we ? hd_wdata : '0;
        wr_byte_en <= hd_we ? hd_be : '0;
      end
      if (rsp_ok) rsp_rdata <= rdata;
      else if (rsp_tmo) rsp_rdata <= 32'hDEAD_BEEF;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {req_we, req_addr, req_wdata, req_be};
`ifdef HYPERRAM_REQ_BRIDGE_RD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  // A rd_rdy arriving in the expiry cycle takes precedence over the timeout.
  assign rsp_tmo = state == WAIT_RD && !rd_rdy && tmo_cnt == 32'(RD_TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tmo_cnt <= state == WAIT_RD ? tmo_cnt + 32'd1 : '0;
      rsp_err <= rsp_tmo;
    end
`else
  assign rsp_tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_hyperram_req_bridge.sv
// tb_hyperram_req_bridge: scoreboard bench for hyperram_req_bridge; issue and response expectations are queued at stimulus time.
module tb_hyperram_req_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, busy = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, wr_req, rd_req, rsp_valid, rsp_err, rd_rdy;
  logic [31:0] addr, wdata, rdata, rsp_rdata;
  logic [3:0] wr_byte_en;
  logic rsp_rdy = 1'b0, late_rdy = 1'b0, auto_rsp = 1'b1, busy_at_edge = 1'b0;
  logic [31:0] rsp_data = '0, resp_addr = '0;
  logic [68:0] exp_iss[$];
  logic [32:0] exp_rsp[$];
  int tests = 0, fails = 0, acc_n = 0, stb_n = 0, rsp_n = 0, cyc = 0;
  int last_stb = -1, rd_cyc = 0, rsp_cyc = 0, rsp_lat = 5;

  assign rd_rdy = rsp_rdy | late_rdy;
  assign rdata = late_rdy ? 32'hBAD0_BAD0 : rsp_data;

  hyperram_req_bridge #(.DEPTH(4), .RD_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .addr(addr), .wr_req(wr_req),
    .rd_req(rd_req), .wdata(wdata), .wr_byte_en(wr_byte_en), .busy(busy), .rd_rdy(rd_rdy),
    .rdata(rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_at_edge <= busy;
  end

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a == 32'h200 ? 32'h1234_5678 : (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: compares every strobe/response against the scoreboard queues.
  always @(negedge clk) if (!reset) begin
    if (wr_req || rd_req) begin
      stb_n++;
      chk("single_strobe", 128'(wr_req && rd_req), 128'(0));
      chk("busy_at_issue", 128'(busy_at_edge), 128'(0));
      if (last_stb >= 0) chk("strobe_spacing", 128'(cyc - last_stb >= 3), 128'(1));
      last_stb = cyc;
      if (rd_req) rd_cyc = cyc;
      chk("strobe_expected", 128'(exp_iss.size() != 0), 128'(1));
      if (exp_iss.size() != 0) chk("issue", 128'({wr_req, addr, wdata, wr_byte_en}), 128'(exp_iss.pop_front()));
    end
    chk("ready_vs_occupancy", 128'(req_ready), 128'((acc_n - stb_n) < 4));
    if (rsp_valid) begin
      rsp_n++;
      rsp_cyc = cyc;
      chk("rsp_expected", 128'(exp_rsp.size() != 0), 128'(1));
      if (exp_rsp.size() != 0) chk("response", 128'({rsp_err, rsp_rdata}), 128'(exp_rsp.pop_front()));
    end
  end

  // Controller model: returns read data a fixed or random number of cycles after rd_req.
  initial forever begin
    @(negedge clk);
    if (auto_rsp && rd_req && !reset) begin
      resp_addr = addr;
      repeat (rsp_lat > 0 ? rsp_lat : int'($urandom_range(1, 6))) @(posedge clk);
      #1;
      rsp_rdy = 1'b1;
      rsp_data = rd_val(resp_addr);
      @(posedge clk);
      #1;
      rsp_rdy = 1'b0;
      rsp_data = '0;
    end
  end

  task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    exp_iss.push_back({we, a, we ? d : 32'h0, we ? be : 4'h0});
    if (!we) exp_rsp.push_back({1'b0, rd_val(a)});
  endtask

  task automatic accept();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_in_budget", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    acc_n++;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    put(we, a, d, be);
    accept();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 128'(exp_iss.size() + exp_rsp.size()), 128'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, r0;
    #1;
    chk("reset_outputs", {addr, wdata, wr_byte_en, wr_req, rd_req, rsp_valid, rsp_rdata, rsp_err, req_ready}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    // single write
    send(1'b1, 32'h100, 32'hA5A5_0001, 4'b0011);
    drain("drain_write");
    chk("write_count", 128'(stb_n), 128'(1));
    chk("no_rsp_for_write", 128'(rsp_n), 128'(0));
    chk("addr_hold", 128'(addr), 128'(32'h100));
    // single read, five-cycle controller latency
    send(1'b0, 32'h200, 32'hFFFF_FFFF, 4'hF);
    drain("drain_read");
    chk("read_rsp_count", 128'(rsp_n), 128'(1));
    chk("rsp_rdata_hold", 128'(rsp_rdata), 128'(32'h1234_5678));
    // fill while busy, then release
    busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send(1'b1, 32'h1000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 4'(k));
      chk("ready_after_push", 128'(req_ready), 128'(k < 4));
    end
    s0 = stb_n;
    put(1'b1, 32'h1014, 32'hC0DE_0005, 4'hF);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("full_stall_ready", 128'(req_ready), 128'(0));
    end
    chk("no_strobe_while_busy", 128'(stb_n), 128'(s0));
    busy = 1'b0;
    accept();
    drain("drain_fill");
    chk("fill_strobes", 128'(stb_n - s0), 128'(5));
    // alternating traffic with random busy stalls and random read latency
    rsp_lat = 0;
    for (int i = 0; i < 10; i++) begin
      busy = $urandom_range(0, 2) == 0;
      send(i[0] == 1'b0, 32'h400 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    busy = 1'b0;
    drain("drain_wrap");
    // reset while a read is outstanding and two entries are queued
    auto_rsp = 1'b0;
    send(1'b0, 32'h300, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    send(1'b1, 32'h304, 32'h1111_2222, 4'hF);
    send(1'b1, 32'h308, 32'h3333_4444, 4'hF);
    chk("read_issued_before_reset", 128'(exp_iss.size()), 128'(2));
    reset = 1'b1;
    #1;
    chk("reset_midop_outputs", {addr, wdata, wr_byte_en, wr_req, rd_req, rsp_valid, rsp_rdata, rsp_err, req_ready}, '0);
    exp_iss.delete();
    exp_rsp.delete();
    acc_n = 0;
    stb_n = 0;
    last_stb = -1;
    r0 = rsp_n;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ready_after_midop_reset", 128'(req_ready), 128'(1));
    late_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    late_rdy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("late_rdy_ignored", 128'(rsp_n), 128'(r0));
    chk("no_strobe_after_reset", 128'(stb_n), 128'(0));
`ifdef HYPERRAM_REQ_BRIDGE_RD_TIMEOUT_EN
    send(1'b0, 32'h500, 32'h0, 4'h0);
    exp_rsp[exp_rsp.size() - 1] = {1'b1, 32'hDEAD_BEEF};
    send(1'b1, 32'h504, 32'h5555_6666, 4'h3);
    drain("drain_timeout");
    chk("timeout_latency", 128'(rsp_cyc - rd_cyc), 128'(17));
    chk("issue_after_timeout", 128'(last_stb > rsp_cyc), 128'(1));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
